// File: rtl/rf_wport_arbiter_pkg.sv
// Purpose: shared widths, arbiter select encoding and the buffered-result payload
// for the register-file write-port arbiter.
package rf_wport_arbiter_pkg;

  localparam int unsigned XLEN           = 64;
  localparam int unsigned NREG           = 32;
  localparam int unsigned REG_IDX_W      = 5;
  localparam int unsigned STARVE_MAX_DEF = 4;

  // Which requester owns the write port this cycle
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_WB   = 2'd1;
  localparam logic [1:0] SEL_MD   = 2'd2;

  // One buffered MUL/DIV result
  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wr_pkt_t;

endpackage

// File: rtl/rf_wport_arbiter_if.sv
// Purpose: bundles every WB, MUL/DIV, ID-hazard and register-file signal of the
// write-port arbiter.
//   slave  : arbiter view (requests/lookups in, grants/write port out)
//   master : pipeline/register-file view (the reverse)
interface rf_wport_arbiter_if;
  import rf_wport_arbiter_pkg::*;

  logic                 wb_req;
  logic [REG_IDX_W-1:0] wb_waddr;
  logic [XLEN-1:0]      wb_wdata;
  logic                 wb_gnt;

  logic                 md_issue;
  logic [REG_IDX_W-1:0] md_issue_rd;
  logic                 md_done_valid;
  logic [REG_IDX_W-1:0] md_done_rd;
  logic [XLEN-1:0]      md_done_data;
  logic                 md_done_ready;

  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic [REG_IDX_W-1:0] id_rd;
  logic                 id_hazard;

  logic                 rf_wen;
  logic [REG_IDX_W-1:0] rf_waddr;
  logic [XLEN-1:0]      rf_wdata;

  modport slave (
    input  wb_req, wb_waddr, wb_wdata,
    input  md_issue, md_issue_rd, md_done_valid, md_done_rd, md_done_data,
    input  id_rs1, id_rs2, id_rd,
    output wb_gnt, md_done_ready, id_hazard, rf_wen, rf_waddr, rf_wdata
  );

  modport master (
    output wb_req, wb_waddr, wb_wdata,
    output md_issue, md_issue_rd, md_done_valid, md_done_rd, md_done_data,
    output id_rs1, id_rs2, id_rd,
    input  wb_gnt, md_done_ready, id_hazard, rf_wen, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/rf_wport_arbiter_scoreboard.sv
// Purpose: pending-destination scoreboard for in-flight MUL/DIV results and the
// three-port ID hazard lookup.
//   clk, rst        : clock, synchronous active-high reset
//   set_en/set_idx  : mark a destination pending (MUL/DIV issue)
//   clr_en/clr_idx  : clear a destination (buffered result written)
//   rs1/rs2/rd      : ID lookup indices
//   hazard          : any looked-up register pending (combinational)
module rf_scoreboard
  import rf_wport_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic [REG_IDX_W-1:0] rd,
  output logic                 hazard
);

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  // Clear first so a same-index set in the same cycle wins; x0 never pends
  always_comb begin
    pend_d = pend_q;
    if (clr_en) pend_d[clr_idx] = 1'b0;
    if (set_en) pend_d[set_idx] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  always_comb begin
    hazard = ((rs1 != '0) & pend_q[rs1]) |
             ((rs2 != '0) & pend_q[rs2]) |
             ((rd  != '0) & pend_q[rd]);
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Purpose: shares the single integer register-file write port between WB and the
// MUL/DIV unit, with a one-entry result buffer, bounded-starvation priority and a
// pending-destination scoreboard for ID hazards.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rf_wport_arbiter_if.slave (WB request/grant, MUL/DIV issue and
//              result handshake, ID hazard lookup, register-file write port)
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  rf_wport_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  wr_pkt_t          buf_q, buf_d;
  logic             buf_valid_q, buf_valid_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic             md_sel;
  logic [1:0]       sel;
  logic             accept;
  logic             hazard_raw;

  // Buffered result wins when WB is idle or it has lost STARVE_MAX times in a row
  always_comb begin
    md_sel = buf_valid_q & (~bus.wb_req | (starve_cnt_q == CNT_W'(STARVE_MAX)));
    sel    = SEL_NONE;
    if (md_sel)          sel = SEL_MD;
    else if (bus.wb_req) sel = SEL_WB;
    accept = bus.md_done_valid & ~buf_valid_q;
  end

  // Output stage; everything held at 0 while in reset
  always_comb begin
    bus.wb_gnt        = 1'b0;
    bus.md_done_ready = 1'b0;
    bus.id_hazard     = 1'b0;
    bus.rf_wen        = 1'b0;
    bus.rf_waddr      = '0;
    bus.rf_wdata      = '0;
    if (!rst) begin
      bus.wb_gnt        = (sel == SEL_WB);
      bus.md_done_ready = ~buf_valid_q;
      bus.id_hazard     = hazard_raw;
      case (sel)
        SEL_MD: begin
          bus.rf_wen   = (buf_q.rd != '0);
          bus.rf_waddr = buf_q.rd;
          bus.rf_wdata = buf_q.data;
        end
        SEL_WB: begin
          bus.rf_wen   = (bus.wb_waddr != '0);
          bus.rf_waddr = bus.wb_waddr;
          bus.rf_wdata = bus.wb_wdata;
        end
        default: ;
      endcase
    end
  end

  // Buffer and starvation counter next state; accept only happens on an empty
  // buffer, so it never collides with a grant of the buffered entry
  always_comb begin
    buf_d        = buf_q;
    buf_valid_d  = buf_valid_q;
    starve_cnt_d = starve_cnt_q;
    if (md_sel) buf_valid_d = 1'b0;
    if (accept) begin
      buf_valid_d = 1'b1;
      buf_d.rd    = bus.md_done_rd;
      buf_d.data  = bus.md_done_data;
    end
    if (!buf_valid_q || md_sel)
      starve_cnt_d = '0;
    else if (starve_cnt_q != CNT_W'(STARVE_MAX))
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q        <= '0;
      buf_valid_q  <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      buf_q        <= buf_d;
      buf_valid_q  <= buf_valid_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  rf_scoreboard u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (bus.md_issue & (bus.md_issue_rd != '0)),
    .set_idx (bus.md_issue_rd),
    .clr_en  (md_sel),
    .clr_idx (buf_q.rd),
    .rs1     (bus.id_rs1),
    .rs2     (bus.id_rs2),
    .rd      (bus.id_rd),
    .hazard  (hazard_raw)
  );

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Randomized + directed scoreboard bench for rf_wport_arbiter.
module tb_rf_wport_arbiter;
  import rf_wport_arbiter_pkg::*;

  localparam int unsigned SMAX = 4;

  typedef struct packed {
    logic gnt;
    logic ready;
    logic haz;
    logic wen;
    logic none;
  } exp_t;

  typedef struct packed {
    logic [4:0]  a;
    logic [63:0] d;
  } wr_t;

  logic clk;
  logic rst;
  rf_wport_arbiter_if bus();

  rf_wport_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t cyc_q[$];
  wr_t  wr_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: set of pending registers, optional buffered result, loss streak
  bit          m_pend[32];
  bit          m_bv;
  logic [4:0]  m_brd;
  logic [63:0] m_bd;
  int          m_loss;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, predict outputs from the reference, advance the reference
  task automatic step(input bit r, input bit wq, input logic [4:0] wa, input logic [63:0] wd,
                      input bit iss, input logic [4:0] ird,
                      input bit dv, input logic [4:0] drd, input logic [63:0] dd,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                      output bit o_gnt, output bit o_acc);
    exp_t e;
    bit   md_wins;
    rst               = r;
    bus.wb_req        = wq;
    bus.wb_waddr      = wa;
    bus.wb_wdata      = wd;
    bus.md_issue      = iss;
    bus.md_issue_rd   = ird;
    bus.md_done_valid = dv;
    bus.md_done_rd    = drd;
    bus.md_done_data  = dd;
    bus.id_rs1        = s1;
    bus.id_rs2        = s2;
    bus.id_rd         = d;
    e = '0;
    o_gnt = 0;
    o_acc = 0;
    if (r) begin
      e.none = 1;
      foreach (m_pend[i]) m_pend[i] = 0;
      m_bv   = 0;
      m_loss = 0;
    end else begin
      md_wins = m_bv && (!wq || m_loss == SMAX);
      e.gnt   = wq && !md_wins;
      e.ready = !m_bv;
      e.haz   = (s1 != 0 && m_pend[s1]) || (s2 != 0 && m_pend[s2]) || (d != 0 && m_pend[d]);
      e.none  = !md_wins && !wq;
      if (md_wins && m_brd != 0) begin
        e.wen = 1;
        wr_q.push_back({m_brd, m_bd});
      end else if (e.gnt && wa != 0) begin
        e.wen = 1;
        wr_q.push_back({wa, wd});
      end
      o_gnt = e.gnt;
      o_acc = dv && e.ready;
      // advance reference
      m_loss = (m_bv && !md_wins) ? ((m_loss < SMAX) ? m_loss + 1 : SMAX) : 0;
      if (md_wins) begin
        m_pend[m_brd] = 0;
        m_bv = 0;
      end
      if (iss && ird != 0) m_pend[ird] = 1;
      if (o_acc) begin
        m_bv  = 1;
        m_brd = drd;
        m_bd  = dd;
      end
    end
    cyc_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit r, input logic [4:0] s1);
    bit g, a;
    step(r, 0, 5'd0, 64'd0, 0, 5'd0, 0, 5'd0, 64'd0, s1, 5'd0, 5'd0, g, a);
  endtask

  // Monitor: compare every presented cycle, and pop a write whenever the port writes
  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      exp_t e;
      wr_t  w;
      e = cyc_q.pop_front();
      chk("wb_gnt",        64'(bus.wb_gnt),        64'(e.gnt));
      chk("md_done_ready", 64'(bus.md_done_ready), 64'(e.ready));
      chk("id_hazard",     64'(bus.id_hazard),     64'(e.haz));
      chk("rf_wen",        64'(bus.rf_wen),        64'(e.wen));
      if (e.none) begin
        chk("rf_waddr_idle", 64'(bus.rf_waddr), 64'd0);
        chk("rf_wdata_idle", bus.rf_wdata,      64'd0);
      end
      if (bus.rf_wen) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", 64'(bus.rf_waddr), 64'h0);
        end else begin
          w = wr_q.pop_front();
          chk("rf_waddr", 64'(bus.rf_waddr), 64'(w.a));
          chk("rf_wdata", bus.rf_wdata,      w.d);
        end
      end
    end
  end

  initial begin
    bit          g, a, hold, dvh, r, wq, iss;
    logic [4:0]  wa, ird, drd_h, s1, s2, d;
    logic [63:0] wd, dd_h;
    logic [4:0]  mdq[$];

    rst = 1'b1;
    bus.wb_req = 0; bus.wb_waddr = 0; bus.wb_wdata = 0;
    bus.md_issue = 0; bus.md_issue_rd = 0;
    bus.md_done_valid = 0; bus.md_done_rd = 0; bus.md_done_data = 0;
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    @(posedge clk);
    #1;

    // Reset
    idle(1, 5'd0);
    idle(1, 5'd0);

    // MUL to x5 with ID reading x5 until it is written
    step(0, 0, 0, 0, 1, 5'd5, 0, 0, 0, 5'd5, 0, 0, g, a);
    repeat (3) idle(0, 5'd5);
    step(0, 0, 0, 0, 0, 0, 1, 5'd5, 64'hDEAD_BEEF, 5'd5, 0, 0, g, a);
    repeat (3) idle(0, 5'd5);

    // Result to x7 with WB idle
    step(0, 0, 0, 0, 1, 5'd7, 0, 0, 0, 5'd7, 0, 0, g, a);
    step(0, 0, 0, 0, 0, 0, 1, 5'd7, 64'h1234, 0, 5'd7, 0, g, a);
    idle(0, 5'd7);
    idle(0, 5'd7);

    // WB held continuously against a buffered result: four grants, then one hold
    step(0, 0, 0, 0, 1, 5'd9, 1, 5'd9, 64'hAAAA_5555_0000_1111, 0, 0, 0, g, a);
    repeat (8) step(0, 1, 5'd3, 64'h3333, 0, 0, 0, 0, 0, 5'd9, 0, 0, g, a);
    idle(0, 5'd0);

    // x0 destinations on both sides
    step(0, 1, 5'd0, 64'h77, 1, 5'd0, 0, 0, 0, 0, 0, 0, g, a);
    idle(0, 5'd0);

    // Buffer full while a second result waits
    step(0, 0, 0, 0, 0, 0, 1, 5'd9, 64'h9999, 0, 0, 0, g, a);
    repeat (6) step(0, 1, 5'd4, 64'h4444, 0, 0, 1, 5'd10, 64'hA0A0, 0, 0, 0, g, a);
    idle(0, 5'd0);
    idle(0, 5'd0);

    // Reset with a buffered result and x3 pending
    step(0, 0, 0, 0, 1, 5'd3, 1, 5'd12, 64'hC, 0, 0, 0, g, a);
    step(0, 1, 5'd1, 64'h1, 0, 0, 0, 0, 0, 5'd3, 0, 0, g, a);
    idle(1, 5'd3);
    idle(0, 5'd3);
    idle(0, 5'd12);

    // Randomized traffic with the bench acting as WB and the MUL/DIV unit
    hold = 0; dvh = 0; wq = 0; wa = 0; wd = 0; drd_h = 0; dd_h = 0;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom % 300) == 0;
      if (!hold) begin
        wq = ($urandom % 3) != 0;
        wa = 5'($urandom);
        wd = {$urandom, $urandom};
      end
      iss = (mdq.size() < 3) && (($urandom % 4) == 0);
      ird = 5'($urandom);
      if (!dvh && mdq.size() > 0 && ($urandom % 2) == 1) begin
        dvh   = 1;
        drd_h = mdq.pop_front();
        dd_h  = {$urandom, $urandom};
      end
      s1 = (mdq.size() > 0 && ($urandom % 2) == 1) ? mdq[0] : 5'($urandom);
      s2 = 5'($urandom);
      d  = 5'($urandom);
      step(r, wq, wa, wd, iss, ird, dvh, drd_h, dd_h, s1, s2, d, g, a);
      if (iss && !r) mdq.push_back(ird);
      if (a) dvh = 0;
      hold = wq && !g && !r;
      if (r) begin
        mdq.delete();
        dvh  = 0;
        hold = 0;
      end
    end

    idle(0, 5'd0);
    repeat (2) @(negedge clk);
    chk("writes_drained", 64'(wr_q.size()), 64'd0);
    chk("cycles_drained", 64'(cyc_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
